// File: rtl/seq_packetizer.sv
// Serializes one REC_W-bit sequence record per handshake into a WORD_W-bit valid/ready/last stream.
// Optional header word per packet: define SEQ_PKT_HDR_EN.
module seq_packetizer #(
    parameter int REC_W  = 296,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:REC_W-1]  recIn,
    input  logic              recIn_val,
    output logic              recIn_ready,
    output logic [WORD_W-1:0] dataOut,
    output logic              dataOut_val,
    input  logic              dataOut_ready,
    output logic              dataOut_last,
    output logic [CNT_W-1:0]  packetsSent
);

    localparam int NWORDS = (REC_W + WORD_W - 1) / WORD_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic ONE_WORD = (NWORDS == 1);

`ifdef SEQ_PKT_HDR_EN
    typedef enum logic [1:0] {IDLE, SEND, HDR} state_t;
    localparam state_t FIRST_STATE = HDR;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
    localparam state_t FIRST_STATE = SEND;
`endif

    state_t stateReg, stateNext;

    logic [IDX_W-1:0]        idxReg, idxNext, idxInc;
    logic [0:REC_W-1]        recReg, recNext;
    logic [WORD_W-1:0]       dataNext;
    logic                    valNext, lastNext;
    logic [CNT_W-1:0]        packetsNext;
    logic [0:NWORDS*WORD_W-1] regPad;
    logic [WORD_W-1:0]       regWords [NWORDS];
    logic [WORD_W-1:0]       firstWord;
    logic                    accept, xfer, lastXfer;

    // Zero-pad the held record to a whole number of words; bit 0 lands in the MSB of word 0.
    always_comb begin
        regPad = '0;
        regPad[0:REC_W-1] = recReg;
    end

    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : gen_words
            assign regWords[gi] = regPad[gi*WORD_W +: WORD_W];
        end
    endgenerate

    always_comb begin
        recIn_ready = 1'b0;
        if (!reset) begin
            case (stateReg)
                IDLE:    recIn_ready = 1'b1;
                SEND:    recIn_ready = dataOut_last && dataOut_ready;
                default: recIn_ready = 1'b0;
            endcase
        end
    end

    assign accept   = recIn_val && recIn_ready;
    assign xfer     = dataOut_val && dataOut_ready;
    assign lastXfer = xfer && dataOut_last;
    assign idxInc   = idxReg + IDX_W'(1);
    assign packetsNext = lastXfer ? packetsSent + CNT_W'(1) : packetsSent;

    // The header carries the count as it will read after this cycle, so a
    // back-to-back header already reflects the packet finishing right now.
`ifdef SEQ_PKT_HDR_EN
    assign firstWord = WORD_W'({16'hA55A, packetsNext[7:0], 8'(NWORDS)});
`else
    assign firstWord = recIn[0 +: WORD_W];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: if (accept) stateNext = FIRST_STATE;
`ifdef SEQ_PKT_HDR_EN
            HDR:  if (xfer) stateNext = SEND;
`endif
            SEND: if (lastXfer) stateNext = accept ? FIRST_STATE : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        recNext  = accept ? recIn : recReg;
        idxNext  = idxReg;
        dataNext = dataOut;
        valNext  = dataOut_val;
        lastNext = dataOut_last;
        case (stateReg)
            IDLE: begin
                if (accept) begin
                    idxNext  = '0;
                    dataNext = firstWord;
                    valNext  = 1'b1;
`ifdef SEQ_PKT_HDR_EN
                    lastNext = 1'b0;
`else
                    lastNext = ONE_WORD;
`endif
                end
            end
`ifdef SEQ_PKT_HDR_EN
            HDR: begin
                if (xfer) begin
                    idxNext  = '0;
                    dataNext = regWords[0];
                    lastNext = ONE_WORD;
                end
            end
`endif
            SEND: begin
                if (xfer) begin
                    if (dataOut_last) begin
                        if (accept) begin
                            idxNext  = '0;
                            dataNext = firstWord;
                            valNext  = 1'b1;
`ifdef SEQ_PKT_HDR_EN
                            lastNext = 1'b0;
`else
                            lastNext = ONE_WORD;
`endif
                        end else begin
                            dataNext = '0;
                            valNext  = 1'b0;
                            lastNext = 1'b0;
                        end
                    end else begin
                        idxNext  = idxInc;
                        dataNext = regWords[idxInc];
                        lastNext = (idxInc == IDX_W'(NWORDS - 1));
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idxReg       <= '0;
            dataOut      <= '0;
            dataOut_val  <= 1'b0;
            dataOut_last <= 1'b0;
            packetsSent  <= '0;
        end else begin
            idxReg       <= idxNext;
            dataOut      <= dataNext;
            dataOut_val  <= valNext;
            dataOut_last <= lastNext;
            packetsSent  <= packetsNext;
        end
    end

    // The record holding register needs no reset: it is only read while a packet is in flight.
    always_ff @(posedge clk) begin
        recReg <= recNext;
    end

endmodule

// File: doc/seq_packetizer.md
Name: seq_packetizer

Overview:
- Transmit-side counterpart of the sequence parser.
- Accepts one 296-bit sequence record per handshake and serializes it into a 32-bit word stream with valid/ready/last framing.
- That stream is exactly the format the parser's dataIn/dataIn_val/dataIn_ready/dataIN_last port consumes.
- Sits upstream of the parser in loopback benches and in the TX path of the design.

Parameters:
- REC_W, 296, record width in bits; record port indexed [0:REC_W-1], bit 0 is first on the wire.
- WORD_W, 32, output word width.
- NWORDS, ceil(REC_W/WORD_W) = 10, payload words per packet (derived localparam, not overridable).
- CNT_W, 16, width of the packetsSent counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- recIn  input  [0:REC_W-1]  record to transmit.
- recIn_val  input  1  record valid.
- recIn_ready  output  1  block can accept a record this cycle.
- dataOut  output  [WORD_W-1:0]  serialized word.
- dataOut_val  output  1  word valid.
- dataOut_ready  input  1  downstream accepts word.
- dataOut_last  output  1  marks the final word of a packet.
- packetsSent  output  [CNT_W-1:0]  count of completed packets.

Behaviour:
- Reset (synchronous, active-high; asserting it mid-packet discards the held record):
  - dataOut_val=0, dataOut_last=0, dataOut=0, packetsSent=0, state=IDLE, word index idx=0.
  - recIn_ready=0 while reset is high.
- States:
  - IDLE: recIn_ready=1, dataOut_val=0.
  - SEND: transmitting words from the internal record register.
  - (HDR when PKT_HDR_EN is defined.)
- Record capture:
  - A record is accepted on a cycle where recIn_val && recIn_ready.
  - On accept, recIn is latched into the record register, idx=0, state -> SEND.
  - dataOut_val rises on the next cycle. Latency from accept to first word valid is 1 cycle.
- Word mapping:
  - Word k carries record bits [k*WORD_W .. k*WORD_W+WORD_W-1].
  - Record bit k*WORD_W goes to dataOut[WORD_W-1] (MSB first).
  - Final word k=9 carries bits 288..295 in dataOut[31:24]; dataOut[23:0]=0 (zero pad).
- Output handshake:
  - A word transfers when dataOut_val && dataOut_ready.
  - While dataOut_val && !dataOut_ready, dataOut and dataOut_last hold stable.
  - dataOut_val never drops without a transfer, except on reset.
- Index and last:
  - idx increments on each transfer.
  - dataOut_last=1 exactly when idx==NWORDS-1 and dataOut_val=1.
- End of packet: on transfer of the last word, packetsSent increments. packetsSent wraps from 2^CNT_W-1 to 0.
- Back-to-back packets:
  - In SEND, recIn_ready = dataOut_last && dataOut_ready (combinational).
  - If recIn_val is also high in that cycle, the new record is latched, idx=0, and state stays SEND.
  - The first word of the new packet is valid on the very next cycle, giving zero idle cycles between packets.
  - Otherwise state -> IDLE and dataOut_val=0 next cycle.
- recIn_val while busy (not at last-word transfer): recIn_ready=0, record not accepted, no side effect.
- dataOut_ready may be held low indefinitely; the block simply stalls.
- All outputs are registered except recIn_ready.

Optional Feature:
- Macro: SEQ_PKT_HDR_EN.
- Defined:
  - A header word is prepended to each packet; state order is IDLE -> HDR -> SEND.
  - Header = {16'hA55A, packetsSent[7:0], 8'(NWORDS)}.
  - Packet length becomes NWORDS+1 = 11 words; dataOut_last still marks the final payload word.
  - The back-to-back path goes to HDR instead of SEND.
- Undefined: no header and no HDR state; packet is exactly NWORDS words.

Test Plan:
- Single packet, ready held high: record with word k = 32'h1000_0000+k (last byte 8'h09) -> 10 consecutive valid cycles starting 1 cycle after accept. Data 0x10000000..0x10000008, then 0x09000000 with last=1; packetsSent=1.
- Backpressure: dataOut_ready toggles every cycle (mirrors parser bench) -> each word held stable while not ready, no duplicates or drops, 10 transfers total, last only on the 10th.
- Back-to-back: second record presented during last-word transfer -> recIn_ready=1 that cycle; next cycle dataOut_val=1 with word 0 of record 2; no bubble; packetsSent=2.
- Busy rejection: recIn_val held high during words 0..8 -> recIn_ready=0 throughout; exactly one record consumed at last word.
- Reset mid-packet: reset asserted after word 4 -> next cycle dataOut_val=0, packetsSent=0. Fresh record afterwards is sent from word 0.
- With SEQ_PKT_HDR_EN defined: first packet header 0xA55A000A, second 0xA55A010A; 11 words per packet, last on the 11th.
